// File: rtl/imem_loader_if.sv
// Byte-stream program load handshake plus instruction-memory write port and load status.
// The loader is the slave of the byte stream; the host/programmer side is the master.
interface imem_loader_if #(
  parameter int unsigned ADDR_WIDTH = 6
);
  logic                  start;
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_last;
  logic                  byte_ready;
  logic                  mem_we;
  logic [31:0]           mem_addr;
  logic [31:0]           mem_wdata;
  logic [ADDR_WIDTH:0]   words_loaded;
  logic                  done;
  logic                  error;
  logic                  cpu_reset;

  modport master (
    output start, byte_valid, byte_data, byte_last,
    input  byte_ready, mem_we, mem_addr, mem_wdata, words_loaded, done, error, cpu_reset
  );

  modport slave (
    input  start, byte_valid, byte_data, byte_last,
    output byte_ready, mem_we, mem_addr, mem_wdata, words_loaded, done, error, cpu_reset
  );
endinterface

// File: rtl/imem_loader.sv
// Packs a little-endian byte stream into 32-bit words and writes them to instruction memory,
// holding the CPU in reset until the whole program is resident.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic         clk,
  input  logic         reset,
  imem_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [31:0]         buf_q, buf_d;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;
  logic                last_q, last_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.start) begin
          state_d = S_LOAD;
          idx_d   = '0;
          buf_d   = '0;
          cnt_d   = '0;
          last_d  = 1'b0;
        end
      end
      S_LOAD: begin
        if (bus.byte_valid) begin
          buf_d[{idx_q, 3'b000} +: 8] = bus.byte_data;
          idx_d = idx_q + 2'd1;
          if (bus.byte_last) begin
            last_d = 1'b1;
          end
          if (idx_q == 2'd3 || bus.byte_last) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        cnt_d = cnt_q + (ADDR_WIDTH + 1)'(1);
        buf_d = '0;
        idx_d = '0;
        // A final word that exactly fills memory is a success, so last wins over full.
        if (last_q) begin
          state_d = S_DONE;
        end else if (cnt_q[ADDR_WIDTH-1:0] == '1) begin
          state_d = S_ERROR;
        end else begin
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign bus.byte_ready   = (state_q == S_LOAD);
  assign bus.mem_we       = (state_q == S_WRITE);
  assign bus.done         = (state_q == S_DONE);
  assign bus.error        = (state_q == S_ERROR);
  assign bus.cpu_reset    = (state_q != S_DONE);
  assign bus.mem_addr     = 32'({cnt_q[ADDR_WIDTH-1:0], 2'b00});
  assign bus.mem_wdata    = buf_q;
  assign bus.words_loaded = cnt_q;

endmodule
